ti_sbox_layer_ctrl: RTL and testbench
=====================================

TI_SBOX_LAYER_CTRL -- requirements
Module: ti_sbox_layer_ctrl

Interface
REQ-001 Parameter NIBBLES, default 16: number of 4-bit S-box lanes per layer; state width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle request to process the loaded state; sampled only in IDLE.
REQ-005 sh0_in, sh1_in  input  W each  two Boolean shares of the state; captured on accepted start.
REQ-006 rnd  input  4  fresh mask nibble for remasking between TI stages.
REQ-007 rnd_valid  input  1  rnd is fresh this cycle.
REQ-008 rnd_req  output  1  controller consumes rnd this cycle.
REQ-009 s1_in  output  8  {share1 nibble, share0 nibble} to first TI stage.
REQ-010 s1_out  input  8  first-stage shared result, same packing.
REQ-011 s2_in  output  8  registered, remasked stage-1 result to second TI stage.
REQ-012 s2_out  input  8  second-stage shared S-box result.
REQ-013 sh0_out, sh1_out  output  W each  result shares.
REQ-014 busy  output  1  high outside IDLE.
REQ-015 done  output  1  one-cycle pulse; result shares valid from this cycle until next accepted start.

Function
REQ-016 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after issuing nibble NIBBLES-1; DRAIN->DONE after final write-back; DONE->IDLE unconditionally.
REQ-017 On accepted start: capture sh0_in/sh1_in into working registers, clear issue index and write index to 0, clear mid-valid flag.
REQ-018 In RUN, issue index i selects nibble bits [4i+3:4i] of both working shares onto s1_in.
REQ-019 rnd_req = 1 in RUN when rnd_valid = 1; an issue occurs only when rnd_req = 1.
REQ-020 On issue: mid register <= {s1_out[7:4] ^ rnd, s1_out[3:0] ^ rnd}; mid-valid <= 1; issue index increments.
REQ-021 Remask preserves share XOR; rnd shall never be applied to one share only.
REQ-022 s2_in = mid register at all times; s2_out is combinational from it.
REQ-023 When mid-valid = 1 in a cycle where the mid register is overwritten (issue) or in DRAIN, nibble at write index of sh0_out/sh1_out <= s2_out[3:0]/s2_out[7:4]; write index increments.
REQ-024 Stall (RUN, rnd_valid = 0): no issue, mid register and mid-valid hold, no write-back; no cycle limit.
REQ-025 DRAIN performs exactly one write-back (nibble NIBBLES-1) and never asserts rnd_req.
REQ-026 Unstalled latency: start accepted cycle 0, issues cycles 1..NIBBLES, write-backs cycles 2..NIBBLES+1, done in cycle NIBBLES+2.
REQ-027 start while busy is ignored; inputs sh0_in/sh1_in are not sampled after capture.
REQ-028 Index counters are ceil(log2(NIBBLES)) bits; no wrap occurs within a layer.
REQ-029 Untouched result nibbles are never written; sh0_out/sh1_out change only via REQ-023.

Reset
REQ-030 rst_n low at a clock edge: state IDLE, all counters 0, mid register 0, mid-valid 0, sh0_out/sh1_out 0, busy 0, done 0, rnd_req 0.
REQ-031 Reset mid-layer aborts the operation with no done pulse; first post-reset start behaves as from power-up.

Structure
REQ-032 State encoding enum and NIBBLES default reside in shared package ti_sbox_pkg.
REQ-033 Stage functions are external; natural sub-module ti_nibble_mux (nibble select of two shares by index), one instance.

Verification
REQ-034 Reset then start with sh0_in = 0x0123456789ABCDEF, sh1_in = 0, rnd_valid = 1: done at cycle 18; sh0_out^sh1_out equals unshared S-box layer of 0x0123456789ABCDEF.
REQ-035 Same data split randomly into shares, rnd random each cycle: unshared result identical to REQ-034; rnd_req high exactly 16 cycles.
REQ-036 rnd_valid low for 5 cycles after nibble 7 issues: no issue/write-back during stall, done at cycle 23, result unchanged.
REQ-037 start pulsed again in cycles 3 and 17: ignored, single done, working shares unaltered.
REQ-038 rst_n low in cycle 9 of a layer: next cycle busy = 0, outputs 0, no done; fresh start completes correctly.

Source files
------------

// File: rtl/ti_sbox_layer_ctrl_pkg.sv
// ti_sbox_pkg: shared layer-controller state encoding and default lane count.
package ti_sbox_pkg;
    localparam int NIBBLES_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ti_sbox_layer_ctrl_if.sv
// ti_sbox_layer_ctrl_if: host, mask-source and TI-stage signals of the layer controller.
interface ti_sbox_layer_ctrl_if import ti_sbox_pkg::*; #(parameter int NIBBLES = NIBBLES_DEF);
    logic                 start;
    logic [4*NIBBLES-1:0] sh0_in, sh1_in, sh0_out, sh1_out;
    logic [3:0]           rnd;
    logic                 rnd_valid, rnd_req;
    logic [7:0]           s1_in, s1_out, s2_in, s2_out;
    logic                 busy, done;
    modport master (output start, sh0_in, sh1_in, rnd, rnd_valid, s1_out, s2_out,
                    input rnd_req, s1_in, s2_in, sh0_out, sh1_out, busy, done);
    modport slave (input start, sh0_in, sh1_in, rnd, rnd_valid, s1_out, s2_out,
                   output rnd_req, s1_in, s2_in, sh0_out, sh1_out, busy, done);
endinterface

// File: rtl/ti_sbox_layer_ctrl_nibble_mux.sv
// ti_nibble_mux: selects nibble idx of two shares, packed {share1, share0}.
module ti_nibble_mux import ti_sbox_pkg::*; #(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1
) (
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic [IW-1:0]        idx,
    output logic [7:0]           y
);
    assign y = {b[{idx, 2'b00} +: 4], a[{idx, 2'b00} +: 4]};
endmodule

// File: rtl/ti_sbox_layer_ctrl.sv
// ti_sbox_layer_ctrl: streams nibbles of a two-share state through external TI stages,
// remasking both shares with the same fresh nibble between stages.
module ti_sbox_layer_ctrl import ti_sbox_pkg::*; #(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input logic clk,
    input logic rst_n,
    ti_sbox_layer_ctrl_if.slave bus
);
    localparam int W = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    state_t st, nst;
    logic [W-1:0] w0, w1, r0, r1;
    logic [IW-1:0] iidx, widx;
    logic [7:0] mid;
    logic mid_v, iss, wb;
    ti_nibble_mux #(.NIBBLES(NIBBLES), .IW(IW)) u_mux (.a(w0), .b(w1), .idx(iidx), .y(bus.s1_in));
    assign iss = st == RUN && bus.rnd_valid;
    // a stage-2 result is retired whenever mid is about to be replaced, plus once more in DRAIN
    assign wb = mid_v && (iss || st == DRAIN);
    assign bus.rnd_req = iss;
    assign bus.s2_in = mid;
    assign bus.sh0_out = r0;
    assign bus.sh1_out = r1;
    assign bus.busy = st != IDLE;
    assign bus.done = st == DONE;
    always_comb begin
        nst = st == IDLE  ? (bus.start ? RUN : IDLE) :
              st == RUN   ? (iss && iidx == LAST ? DRAIN : RUN) :
              st == DRAIN ? DONE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
            w0 <= '0;
            w1 <= '0;
            r0 <= '0;
            r1 <= '0;
            iidx <= '0;
            widx <= '0;
            mid <= '0;
            mid_v <= 1'b0;
        end else begin
            st <= nst;
            if (st == IDLE && bus.start) begin
                w0 <= bus.sh0_in;
                w1 <= bus.sh1_in;
                iidx <= '0;
                widx <= '0;
                mid_v <= 1'b0;
            end
            if (iss) begin
                mid <= {bus.s1_out[7:4] ^ bus.rnd, bus.s1_out[3:0] ^ bus.rnd};
                mid_v <= 1'b1;
                iidx <= iidx + IW'(iidx != LAST);
            end
            if (wb) begin
                r0[{widx, 2'b00} +: 4] <= bus.s2_out[3:0];
                r1[{widx, 2'b00} +: 4] <= bus.s2_out[7:4];
                widx <= widx + IW'(widx != LAST);
            end
        end
    end
endmodule

// File: tb/tb_ti_sbox_layer_ctrl.sv
// tb_ti_sbox_layer_ctrl: vector table of layers through a PRESENT S-box stage model,
// scoreboard of expected unshared results, plus a mid-layer reset sequence.
module tb_ti_sbox_layer_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    ti_sbox_layer_ctrl_if #(.NIBBLES(16)) bus();
    ti_sbox_layer_ctrl #(.NIBBLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hC56B90AD3EF84712;
        return t[63 - 4 * x -: 4];
    endfunction
    function automatic logic [3:0] rotl(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction
    function automatic logic [3:0] rotr(input logic [3:0] x);
        return {x[0], x[3:1]};
    endfunction
    // stage 1 is linear per share; stage 2 recombines and re-splits with share1 as mask
    always_comb begin
        bus.s1_out = {rotl(bus.s1_in[7:4]), rotl(bus.s1_in[3:0])};
        bus.s2_out = {bus.s2_in[7:4], sbox(rotr(bus.s2_in[7:4] ^ bus.s2_in[3:0])) ^ bus.s2_in[7:4]};
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    typedef struct {
        logic [63:0] d;
        logic        rmask;
        int          mode;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[7];
    // mode 0: plain, 1: rnd_valid low in cycles 9..13, 2: start re-pulsed in cycles 3 and 17
    task automatic run_layer(input vec_t v);
        logic [63:0] m, snap, res;
        int reqs, done_at, stall_req;
        m = v.rmask ? {$urandom, $urandom} : 64'd0;
        sb.push_back(v.exp);
        reqs = 0;
        done_at = -1;
        stall_req = 0;
        snap = '0;
        res = '0;
        @(negedge clk);
        bus.sh0_in = v.d ^ m;
        bus.sh1_in = m;
        bus.start = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd = 4'($urandom);
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            bus.start = v.mode == 2 && (c == 3 || c == 17);
            if (v.mode == 2) begin
                bus.sh0_in = {$urandom, $urandom};
                bus.sh1_in = {$urandom, $urandom};
            end
            bus.rnd_valid = !(v.mode == 1 && c >= 9 && c <= 13);
            bus.rnd = 4'($urandom);
            #1;
            if (bus.rnd_req) reqs++;
            if (v.mode == 1 && c >= 9 && c <= 13 && bus.rnd_req) stall_req++;
            if (c == 9) snap = bus.sh0_out ^ bus.sh1_out;
            if (v.mode == 1 && c == 14) chk("stall_no_writeback", bus.sh0_out ^ bus.sh1_out, snap);
            if (bus.done) begin
                done_at = c;
                res = bus.sh0_out ^ bus.sh1_out;
            end
        end
        chk("done_latency", 64'(done_at), v.mode == 1 ? 64'd23 : 64'd18);
        chk("rnd_req_count", 64'(reqs), 64'd16);
        if (v.mode == 1) chk("stall_rnd_req", 64'(stall_req), 64'd0);
        if (sb.size() == 0) chk("scoreboard_empty", 64'd0, 64'd1);
        else chk("layer_result", res, sb.pop_front());
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("post_done_idle", {62'd0, bus.done, bus.busy}, 64'd0);
        end
    endtask
    initial begin
        tbl[0] = '{64'h0123456789ABCDEF, 1'b0, 0, 64'hC56B90AD3EF84712};
        tbl[1] = '{64'h0123456789ABCDEF, 1'b1, 0, 64'hC56B90AD3EF84712};
        tbl[2] = '{64'h0123456789ABCDEF, 1'b1, 1, 64'hC56B90AD3EF84712};
        tbl[3] = '{64'h0123456789ABCDEF, 1'b1, 2, 64'hC56B90AD3EF84712};
        tbl[4] = '{64'h0000000000000000, 1'b1, 0, 64'hCCCCCCCCCCCCCCCC};
        tbl[5] = '{64'hFEDCBA9876543210, 1'b1, 0, 64'h21748FE3DA09B65C};
        tbl[6] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 1, 64'h2222222222222222};
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sh0_in = '0;
        bus.sh1_in = '0;
        bus.rnd = '0;
        bus.rnd_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_flags", {61'd0, bus.busy, bus.done, bus.rnd_req}, 64'd0);
        chk("reset_sh0", bus.sh0_out, 64'd0);
        chk("reset_sh1", bus.sh1_out, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) run_layer(tbl[i]);
        // abort a layer with reset in cycle 9
        @(negedge clk);
        bus.sh0_in = 64'h0123456789ABCDEF;
        bus.sh1_in = 64'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_flags", {61'd0, bus.busy, bus.done, bus.rnd_req}, 64'd0);
        chk("abort_sh0", bus.sh0_out, 64'd0);
        chk("abort_sh1", bus.sh1_out, 64'd0);
        chk("abort_s2_in", 64'(bus.s2_in), 64'd0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(negedge clk);
                #1;
                if (bus.done || bus.busy) seen++;
            end
            chk("abort_no_done", 64'(seen), 64'd0);
        end
        run_layer(tbl[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
